wb_regfile: RTL

- Architectural general-purpose register file for the 5-stage MIPS32 pipeline.
- Directly downstream of the MEM/WB pipeline register: consumes its registered write-back triple (destination, write-enable, data) and commits it on the next clock edge.
- Provides two combinational read ports to the ID stage.
- Includes write-to-read bypass, so an instruction in ID that reads the register being written back this cycle sees the new value.

---
 rtl/wb_regfile_if.sv | 27 ++
 rtl/wb_regfile.sv | 61 ++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / read-port bundle between the pipeline and the register file.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  // Pipeline side: drives write triple and read addresses, consumes read data.
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  // Register-file side.
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/wb_regfile.sv
// MIPS32 architectural register file: one write port fed by MEM/WB,
// two combinational read ports for ID with same-cycle write bypass.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next-state: commit the write-back triple; register 0 is never written.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.we && (bus.waddr != '0)) begin
      regs_d[bus.waddr] = bus.wdata;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1: reset, enable, $zero, bypass, storage in that priority.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end else begin
        bus.rdata1 = regs_q[bus.raddr1];
      end
    end
  end

  // Read port 2: same priority as port 1, fully independent.
  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end else begin
        bus.rdata2 = regs_q[bus.raddr2];
      end
    end
  end

endmodule
